// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with input filter, parity/framing checks and
// a receive FIFO behind a valid/wait handshake.
// Optional feature: define UART_RX_BREAK_DET_EN to add the brk output and suppress break frames.
module uart_rx_param #(
    parameter int unsigned PULSEW     = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FILT_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 uarti,
    output logic [DATA_BITS-1:0] datao,
    output logic                 valido,
    input  logic                 waito,
    output logic                 perro,
    output logic                 ferro,
    output logic                 ovr,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 brk,
`endif
    output logic                 busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned EntW = DATA_BITS + 2;
    localparam int unsigned DivW = (FILT_DIV > 1) ? $clog2(FILT_DIV) : 1;
    localparam int unsigned IdxW = 4;
    // Reload with PULSEW-1: the zero cycle itself is part of the bit period.
    localparam logic [15:0] BitReload  = 16'(PULSEW - 1);
    localparam logic [15:0] HalfReload = 16'(PULSEW / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkw
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and majority filter
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      hist_q, hist_d;
    logic            uf_q, uf_d;
    logic            filt_tick;
    logic [2:0]      ones;

    // Sample history every FILT_DIV cycles; filtered line is the majority of 5 samples
    always_comb begin
        filt_tick = (div_q == DivW'(FILT_DIV - 1));
        div_d     = filt_tick ? '0 : div_q + DivW'(1);
        hist_d    = filt_tick ? {hist_q[3:0], sync2_q} : hist_q;
        ones      = '0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + {2'b00, hist_q[i]};
        end
        uf_d = (ones >= 3'd3);
    end

    // Synchroniser, divider, history and filtered line registers
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= '0;
            hist_q  <= 5'b11111;
            uf_q    <= 1'b1;
        end else begin
            sync1_q <= uarti;
            sync2_q <= sync1_q;
            div_q   <= div_d;
            hist_q  <= hist_d;
            uf_q    <= uf_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 second_q, second_d;
    logic                 busy_q;
    logic                 at_zero;
    logic                 frame_done;
    logic                 frame_brk;
    logic                 frame_ferr;
    logic                 push_req;

    // Next-state logic: one sample per bit, taken when the down-counter reads zero
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        second_d   = second_q;
        frame_done = 1'b0;
        frame_ferr = 1'b0;
        at_zero    = (cnt_q == 16'd0);

        unique case (state_q)
            StIdle: begin
                if (!uf_q) begin
                    cnt_d   = HalfReload;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!at_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (uf_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d    = BitReload;
                    idx_d    = '0;
                    perr_d   = 1'b0;
                    ferr_d   = 1'b0;
                    second_d = 1'b0;
                    state_d  = StData;
                end
            end
            StData: begin
                if (!at_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {uf_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = BitReload;
                    if (idx_q == IdxW'(DATA_BITS - 1)) begin
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (!at_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    perr_d  = (((^shift_q) ^ uf_q) != (PARITY == 1));
                    cnt_d   = BitReload;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (!at_zero) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    ferr_d = ferr_q | ~uf_q;
                    if (STOP_BITS == 2 && !second_q) begin
                        second_d = 1'b1;
                        cnt_d    = BitReload;
                    end else begin
                        frame_done = 1'b1;
                        frame_ferr = ferr_d;
                        // Completing at mid-stop lets the next start edge be seen at once
                        state_d    = (uf_q && !frame_brk) ? StIdle : StBrkw;
                    end
                end
            end
            StBrkw: begin
                if (uf_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, counters and frame accumulators
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            second_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            second_q <= second_d;
            busy_q   <= (state_d != StIdle);
        end
    end

    assign busy = busy_q;

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_q, par_bit_d;
    logic stop1_q, stop1_d;
    logic brk_q;

    // Remember the parity bit and first stop sample so an all-zero frame reads as a break
    always_comb begin
        par_bit_d = par_bit_q;
        stop1_d   = stop1_q;
        if (at_zero && state_q == StParity) begin
            par_bit_d = uf_q;
        end
        if (at_zero && state_q == StStop && !second_q) begin
            stop1_d = uf_q;
        end
        frame_brk = frame_done && (shift_q == '0) && !par_bit_q &&
                    !(second_q ? stop1_q : uf_q);
    end

    // Break tracking registers and one-cycle break pulse
    always_ff @(posedge clk) begin
        if (srst) begin
            par_bit_q <= 1'b0;
            stop1_q   <= 1'b1;
            brk_q     <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            stop1_q   <= stop1_d;
            brk_q     <= frame_brk;
        end
    end

    assign brk      = brk_q;
    assign push_req = frame_done && !frame_brk;
`else
    assign frame_brk = 1'b0;
    assign push_req  = frame_done;
`endif

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [EntW-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW:0]   wr_q, wr_d, rd_q, rd_d;
    logic            empty, full, pop, push;
    logic            ovr_d, ovr_q;
    logic [EntW-1:0] push_data;

    // Pointer update; a push into a full FIFO survives only if a pop frees a slot this cycle
    always_comb begin
        empty     = (wr_q == rd_q);
        full      = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
        pop       = !empty && !waito;
        push      = push_req && (!full || pop);
        ovr_d     = push_req && full && !pop;
        push_data = {perr_d, frame_ferr, shift_q};
        wr_d      = push ? wr_q + 1'b1 : wr_q;
        rd_d      = pop ? rd_q + 1'b1 : rd_q;
    end

    // FIFO pointers and overrun pulse
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            ovr_q <= ovr_d;
        end
    end

    // FIFO storage; contents are masked at the outputs while empty, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[PtrW-1:0]] <= push_data;
        end
    end

    assign valido                 = !empty;
    assign {perro, ferro, datao}  = empty ? '0 : mem_q[rd_q[PtrW-1:0]];
    assign ovr                    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: an 8N1 instance and a 7E1 instance driven with directed frames.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       srst = 1'b1;

    logic       uarti_a = 1'b1, waito_a = 1'b0;
    logic [7:0] datao_a;
    logic       valido_a, perro_a, ferro_a, ovr_a, busy_a, brk_a;

    logic       uarti_b = 1'b1, waito_b = 1'b0;
    logic [6:0] datao_b;
    logic       valido_b, perro_b, ferro_b, ovr_b, busy_b, brk_b;

    int unsigned total = 0;
    int unsigned passed = 0;

    logic [9:0] q_a[$];
    logic [8:0] q_b[$];
    int unsigned valid_cycles_a = 0;
    int unsigned ovr_cnt_a = 0;
    int unsigned brk_cnt_a = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .PULSEW(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FILT_DIV(1), .FIFO_DEPTH(4)
    ) u_a (
        .clk(clk), .srst(srst), .uarti(uarti_a), .datao(datao_a), .valido(valido_a),
        .waito(waito_a), .perro(perro_a), .ferro(ferro_a), .ovr(ovr_a),
`ifdef UART_RX_BREAK_DET_EN
        .brk(brk_a),
`endif
        .busy(busy_a)
    );

    uart_rx_param #(
        .PULSEW(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FILT_DIV(1), .FIFO_DEPTH(4)
    ) u_b (
        .clk(clk), .srst(srst), .uarti(uarti_b), .datao(datao_b), .valido(valido_b),
        .waito(waito_b), .perro(perro_b), .ferro(ferro_b), .ovr(ovr_b),
`ifdef UART_RX_BREAK_DET_EN
        .brk(brk_b),
`endif
        .busy(busy_b)
    );

`ifndef UART_RX_BREAK_DET_EN
    assign brk_a = 1'b0;
    assign brk_b = 1'b0;
`endif

    // Record popped entries and output pulses, sampled on the falling edge
    always @(negedge clk) begin
        if (!srst) begin
            if (valido_a) valid_cycles_a++;
            if (valido_a && !waito_a) q_a.push_back({perro_a, ferro_a, datao_a});
            if (ovr_a) ovr_cnt_a++;
            if (brk_a) brk_cnt_a++;
            if (valido_b && !waito_b) q_b.push_back({perro_b, ferro_b, datao_b});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive n frame bits LSB first, 16 clocks each
    task automatic send_a(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            uarti_a = bits[i];
            tick(16);
        end
        uarti_a = 1'b1;
    endtask

    task automatic send_b(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            uarti_b = bits[i];
            tick(16);
        end
        uarti_b = 1'b1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        tick(4);
        srst = 1'b0;
        tick(1);
        total++; if (valido_a !== 1'b0) $display("FAIL rst_valid: got %b expected 0", valido_a); else passed++;
        total++; if (datao_a !== 8'h00) $display("FAIL rst_data: got %h expected 00", datao_a); else passed++;
        total++; if (perro_a !== 1'b0) $display("FAIL rst_perr: got %b expected 0", perro_a); else passed++;
        total++; if (ferro_a !== 1'b0) $display("FAIL rst_ferr: got %b expected 0", ferro_a); else passed++;
        total++; if (ovr_a !== 1'b0) $display("FAIL rst_ovr: got %b expected 0", ovr_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_a); else passed++;
        total++; if (brk_a !== 1'b0) $display("FAIL rst_brk: got %b expected 0", brk_a); else passed++;
    endtask

    task automatic test_8n1();
        int base_q, base_v;
        base_q = q_a.size();
        base_v = valid_cycles_a;
        waito_a = 1'b0;
        send_a({6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        tick(30);
        total++; if (q_a.size() - base_q !== 1) $display("FAIL t1_count: got %0d expected 1", q_a.size() - base_q); else passed++;
        if (q_a.size() > base_q) begin
            total++; if (q_a[base_q] !== {2'b00, 8'hA5}) $display("FAIL t1_entry: got %h expected %h", q_a[base_q], {2'b00, 8'hA5}); else passed++;
        end
        total++; if (valid_cycles_a - base_v !== 1) $display("FAIL t1_valid_len: got %0d expected 1", valid_cycles_a - base_v); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL t1_busy: got %b expected 0", busy_a); else passed++;
    endtask

    task automatic test_parity();
        int base_q;
        base_q = q_b.size();
        // 0x03 has even weight, so the correct even parity bit is 0
        send_b({6'b0, 1'b1, 1'b1, 7'h03, 1'b0}, 10);
        tick(30);
        send_b({6'b0, 1'b1, 1'b0, 7'h03, 1'b0}, 10);
        tick(30);
        total++; if (q_b.size() - base_q !== 2) $display("FAIL t2_count: got %0d expected 2", q_b.size() - base_q); else passed++;
        if (q_b.size() >= base_q + 2) begin
            total++; if (q_b[base_q] !== {2'b10, 7'h03}) $display("FAIL t2_bad_par: got %h expected %h", q_b[base_q], {2'b10, 7'h03}); else passed++;
            total++; if (q_b[base_q+1] !== {2'b00, 7'h03}) $display("FAIL t2_good_par: got %h expected %h", q_b[base_q+1], {2'b00, 7'h03}); else passed++;
        end
    endtask

    task automatic test_glitch();
        int base_v, base_q;
        logic saw_busy;
        base_v = valid_cycles_a;
        base_q = q_a.size();
        saw_busy = 1'b0;
        uarti_a = 1'b0;
        tick(4);
        uarti_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (busy_a) saw_busy = 1'b1;
        end
        total++; if (saw_busy !== 1'b1) $display("FAIL t3_start_seen: got %b expected 1", saw_busy); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL t3_busy_back: got %b expected 0", busy_a); else passed++;
        tick(30);
        total++; if (valid_cycles_a - base_v !== 0) $display("FAIL t3_no_valid: got %0d expected 0", valid_cycles_a - base_v); else passed++;
        total++; if (q_a.size() - base_q !== 0) $display("FAIL t3_no_entry: got %0d expected 0", q_a.size() - base_q); else passed++;
    endtask

    task automatic test_back_to_back();
        int base_q, base_o;
        logic [7:0] d;
        base_q = q_a.size();
        base_o = ovr_cnt_a;
        waito_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            d = 8'(k);
            send_a({6'b0, 1'b1, d, 1'b0}, 10);
        end
        tick(30);
        total++; if (ovr_cnt_a - base_o !== 1) $display("FAIL t4_ovr: got %0d expected 1", ovr_cnt_a - base_o); else passed++;
        total++; if (datao_a !== 8'h01) $display("FAIL t4_hold_head: got %h expected 01", datao_a); else passed++;
        waito_a = 1'b0;
        tick(10);
        total++; if (q_a.size() - base_q !== 4) $display("FAIL t4_count: got %0d expected 4", q_a.size() - base_q); else passed++;
        if (q_a.size() >= base_q + 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (q_a[base_q+k] !== {2'b00, 8'(k + 1)})
                    $display("FAIL t4_pop%0d: got %h expected %h", k, q_a[base_q+k], {2'b00, 8'(k + 1)});
                else passed++;
            end
        end
        total++; if (valido_a !== 1'b0) $display("FAIL t4_drained: got %b expected 0", valido_a); else passed++;
    endtask

    task automatic test_framing();
        int base_q, base_b;
        base_q = q_a.size();
        waito_a = 1'b0;
        send_a({6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        tick(30);
        total++; if (q_a.size() - base_q !== 1) $display("FAIL t5_ferr_count: got %0d expected 1", q_a.size() - base_q); else passed++;
        if (q_a.size() > base_q) begin
            total++; if (q_a[base_q] !== {2'b01, 8'h3C}) $display("FAIL t5_ferr_entry: got %h expected %h", q_a[base_q], {2'b01, 8'h3C}); else passed++;
        end
        base_q = q_a.size();
        base_b = brk_cnt_a;
        uarti_a = 1'b0;
        tick(320);
        uarti_a = 1'b1;
        tick(40);
`ifdef UART_RX_BREAK_DET_EN
        total++; if (brk_cnt_a - base_b !== 1) $display("FAIL t5_brk: got %0d expected 1", brk_cnt_a - base_b); else passed++;
        total++; if (q_a.size() - base_q !== 0) $display("FAIL t5_brk_entry: got %0d expected 0", q_a.size() - base_q); else passed++;
`else
        total++; if (brk_cnt_a - base_b !== 0) $display("FAIL t5_brk: got %0d expected 0", brk_cnt_a - base_b); else passed++;
        total++; if (q_a.size() - base_q !== 1) $display("FAIL t5_brk_count: got %0d expected 1", q_a.size() - base_q); else passed++;
        if (q_a.size() > base_q) begin
            total++; if (q_a[base_q] !== {2'b01, 8'h00}) $display("FAIL t5_brk_entry: got %h expected %h", q_a[base_q], {2'b01, 8'h00}); else passed++;
        end
`endif
        total++; if (busy_a !== 1'b0) $display("FAIL t5_busy: got %b expected 0", busy_a); else passed++;
    endtask

    task automatic test_srst_mid_frame();
        int base_q;
        waito_a = 1'b1;
        send_a({6'b0, 1'b1, 8'h11, 1'b0}, 10);
        tick(20);
        total++; if (valido_a !== 1'b1) $display("FAIL t6_pending: got %b expected 1", valido_a); else passed++;
        // Start bit plus data bits 0..2 of 0x5A, then land inside data bit 3
        send_a(16'b0000_0000_0000_0100, 4);
        uarti_a = 1'b1;
        uarti_a = 1'b0;
        tick(10);
        srst = 1'b1;
        uarti_a = 1'b1;
        tick(1);
        srst = 1'b0;
        total++; if (valido_a !== 1'b0) $display("FAIL t6_valid: got %b expected 0", valido_a); else passed++;
        total++; if (datao_a !== 8'h00) $display("FAIL t6_data: got %h expected 00", datao_a); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL t6_busy: got %b expected 0", busy_a); else passed++;
        total++; if ({perro_a, ferro_a, ovr_a} !== 3'b000) $display("FAIL t6_flags: got %b expected 000", {perro_a, ferro_a, ovr_a}); else passed++;
        tick(30);
        waito_a = 1'b0;
        base_q = q_a.size();
        send_a({6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        tick(30);
        total++; if (q_a.size() - base_q !== 1) $display("FAIL t6_count: got %0d expected 1", q_a.size() - base_q); else passed++;
        if (q_a.size() > base_q) begin
            total++; if (q_a[base_q] !== {2'b00, 8'h5A}) $display("FAIL t6_entry: got %h expected %h", q_a[base_q], {2'b00, 8'h5A}); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_back_to_back();
        test_framing();
        test_srst_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
